// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param.
// master = producer/consumer side, slave = the FIFO.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, rvalid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, rvalid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C  = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_n;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_n;
  logic             unf_n;

  // Acceptance uses the registered flags; reset blocks any mem write.
  assign wr_acc = f.winc && !f.full && !rst;
  assign rd_acc = f.rinc && !f.empty && !rst;

  always_comb begin
    cnt_n = cnt;
    unique case (1'b1)
      wr_acc && !rd_acc: cnt_n = cnt + ONE;
      rd_acc && !wr_acc: cnt_n = cnt - ONE;
      default:           cnt_n = cnt;
    endcase
  end

  assign ovf_n = (f.overflow && !f.clr_err)
              || (f.winc && f.full);
  assign unf_n = (f.underflow && !f.clr_err)
              || (f.rinc && f.empty);
  assign f.count = cnt;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[AW-1:0]] <= f.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr           <= '0;
      rptr           <= '0;
      cnt            <= '0;
      f.full         <= 1'b0;
      f.empty        <= 1'b1;
      f.almost_full  <= 1'b0;
      f.almost_empty <= 1'b1;
      f.overflow     <= 1'b0;
      f.underflow    <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;
      cnt            <= cnt_n;
      f.full         <= cnt_n == DEP_C;
      f.empty        <= cnt_n == '0;
      f.almost_full  <= cnt_n >= AF_C;
      f.almost_empty <= cnt_n <= AE_C;
      f.overflow     <= ovf_n;
      f.underflow    <= unf_n;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign f.rdata  = mem[rptr[AW-1:0]];
  assign f.rvalid = !f.empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      f.rdata  <= '0;
      f.rvalid <= 1'b0;
    end else begin
      f.rvalid <= rd_acc;
      if (rd_acc) f.rdata <= mem[rptr[AW-1:0]];
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param.
// Reference is a queue-based model of the FIFO rules.
module tb_sync_fifo_param;
  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] mq [$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_rv = 1'b0;
  logic [W-1:0] m_rd = '0;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f(bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle and advance the model with pre-edge state.
  task automatic step(input logic w, input logic [W-1:0] d,
                      input logic r, input logic c,
                      input logic rs);
    logic fb, eb, wa, ra;
    bus.winc = w; bus.wdata = d; bus.rinc = r;
    bus.clr_err = c; rst = rs;
    @(posedge clk);
    fb = mq.size() == D;
    eb = mq.size() == 0;
    wa = w && !fb;
    ra = r && !eb;
    if (rs) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_rv = ra;
      if (ra) m_rd = mq.pop_front();
      if (wa) mq.push_back(d);
      m_ovf = (m_ovf && !c) || (w && fb);
      m_unf = (m_unf && !c) || (r && eb);
    end
    #1;
    bus.winc = 0; bus.rinc = 0; bus.clr_err = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    checks++; if (bus.count !== 5'd0) begin failures++;
      $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if ({bus.full, bus.empty, bus.almost_full,
                   bus.almost_empty} !== 4'b0101) begin failures++;
      $display("FAIL reset_flags got=%b exp=0101",
        {bus.full, bus.empty, bus.almost_full, bus.almost_empty}); end
    checks++; if ({bus.overflow, bus.underflow, bus.rvalid}
                  !== 3'b000) begin failures++;
      $display("FAIL reset_err_rv got=%b exp=000",
        {bus.overflow, bus.underflow, bus.rvalid}); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (bus.rdata !== 8'h00) begin failures++;
      $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      step(1, W'(i), 0, 0, 0);
      checks++; if (bus.count !== 5'(i)) begin failures++;
        $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); end
      checks++; if (bus.almost_full !== (i >= 12)) begin failures++;
        $display("FAIL fill_af n=%0d got=%b", i, bus.almost_full); end
      checks++; if (bus.full !== (i == D)) begin failures++;
        $display("FAIL fill_full n=%0d got=%b", i, bus.full); end
    end
    step(1, 8'hEE, 0, 0, 0);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16)
    begin failures++;
      $display("FAIL fill_overflow got=%b cnt=%0d exp=1 cnt=16",
        bus.overflow, bus.count); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= D; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (bus.rdata !== W'(i)) begin failures++;
        $display("FAIL drain_head got=%h exp=%h", bus.rdata, W'(i)); end
      step(0, 0, 1, 0, 0);
`else
      step(0, 0, 1, 0, 0);
      checks++; if (bus.rdata !== W'(i) || bus.rvalid !== 1'b1)
      begin failures++;
        $display("FAIL drain_rdata got=%h rv=%b exp=%h rv=1",
          bus.rdata, bus.rvalid, W'(i)); end
`endif
    end
    checks++; if (bus.empty !== 1'b1) begin failures++;
      $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    step(0, 0, 1, 0, 0);
    checks++; if (bus.underflow !== 1'b1) begin failures++;
      $display("FAIL drain_underflow got=%b exp=1", bus.underflow); end
    step(0, 0, 0, 1, 0);
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin
      failures++;
      $display("FAIL clr_err got=%b exp=00",
        {bus.overflow, bus.underflow}); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 10; i++) step(1, W'(i), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (bus.rdata !== W'(i + 1)) begin failures++;
        $display("FAIL wrap_head got=%h exp=%h", bus.rdata, W'(i+1)); end
      step(1, W'(i + 11), 1, 0, 0);
`else
      step(1, W'(i + 11), 1, 0, 0);
      checks++; if (bus.rdata !== W'(i + 1)) begin failures++;
        $display("FAIL wrap_rdata got=%h exp=%h", bus.rdata, W'(i+1)); end
`endif
      checks++; if (bus.count !== 5'd10 || {bus.full, bus.empty,
          bus.almost_full, bus.almost_empty} !== 4'b0000) begin
        failures++;
        $display("FAIL wrap_state cnt=%0d flags=%b exp cnt=10 0000",
          bus.count, {bus.full, bus.empty, bus.almost_full,
          bus.almost_empty}); end
    end
  endtask

  task automatic test_simul_edges();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < D; i++) step(1, W'(8'h40 + i), 0, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    checks++; if (bus.count !== 5'd15 || bus.overflow !== 1'b1)
    begin failures++;
      $display("FAIL full_wr_rd cnt=%0d ovf=%b exp cnt=15 ovf=1",
        bus.count, bus.overflow); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (bus.rdata !== 8'h40) begin failures++;
      $display("FAIL full_wr_rd_data got=%h exp=40", bus.rdata); end
`endif
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'h77, 1, 0, 0);
    checks++; if (bus.count !== 5'd1 || bus.underflow !== 1'b1 ||
                  bus.empty !== 1'b0) begin failures++;
      $display("FAIL empty_wr_rd cnt=%0d unf=%b e=%b exp 1 1 0",
        bus.count, bus.underflow, bus.empty); end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0, 0);
    step(1, 8'h5A, 0, 0, 1);
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 ||
                  bus.full !== 1'b0 || bus.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst cnt=%0d e=%b f=%b rv=%b exp 0 1 0 0",
        bus.count, bus.empty, bus.full, bus.rvalid); end
    step(1, 8'hA5, 0, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (bus.rdata !== 8'hA5) begin failures++;
      $display("FAIL midrst_data got=%h exp=a5", bus.rdata); end
`else
    step(0, 0, 1, 0, 0);
    checks++; if (bus.rdata !== 8'hA5 || bus.rvalid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_data got=%h rv=%b exp=a5 rv=1",
        bus.rdata, bus.rvalid); end
`endif
  endtask

  task automatic test_random();
    int n;
    logic [3:0] ef;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases to hit both ends.
      if ((i / 60) % 2 == 0)
        step($urandom_range(0, 3) != 0, W'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 199) == 0);
      else
        step($urandom_range(0, 3) == 0, W'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 199) == 0);
      n = mq.size();
      ef = {n == D, n == 0, n >= 12, n <= 4};
      checks++; if (bus.count !== 5'(n)) begin failures++;
        $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d",
          i, bus.count, n); end
      checks++; if ({bus.full, bus.empty, bus.almost_full,
                     bus.almost_empty} !== ef) begin failures++;
        $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i,
          {bus.full, bus.empty, bus.almost_full, bus.almost_empty},
          ef); end
      checks++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf})
      begin failures++;
        $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i,
          {bus.overflow, bus.underflow}, {m_ovf, m_unf}); end
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (bus.rvalid !== (n != 0)) begin failures++;
        $display("FAIL rnd_rvalid cyc=%0d got=%b", i, bus.rvalid); end
      if (n != 0) begin
        checks++; if (bus.rdata !== mq[0]) begin failures++;
          $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h",
            i, bus.rdata, mq[0]); end
      end
`else
      checks++; if (bus.rvalid !== m_rv || bus.rdata !== m_rd) begin
        failures++;
        $display("FAIL rnd_read cyc=%0d got=%h/%b exp=%h/%b",
          i, bus.rdata, bus.rvalid, m_rd, m_rv); end
`endif
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    step(0, 0, 0, 0, 1);
    step(1, 8'h3C, 0, 0, 0);
    checks++; if (bus.empty !== 1'b0 || bus.rdata !== 8'h3C ||
                  bus.rvalid !== 1'b1) begin failures++;
      $display("FAIL fwft_fall e=%b d=%h rv=%b exp 0 3c 1",
        bus.empty, bus.rdata, bus.rvalid); end
    step(0, 0, 1, 0, 0);
    checks++; if (bus.empty !== 1'b1) begin failures++;
      $display("FAIL fwft_pop e=%b exp=1", bus.empty); end
  endtask
`endif

  initial begin
    bus.winc = 0; bus.wdata = '0; bus.rinc = 0; bus.clr_err = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_edges();
    test_mid_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
